layer2_weight_bank: RTL and testbench
=====================================

# layer2_weight_bank

Capture-and-serve store for the second convolution layer's kernels, directly downstream of the layer-2 weight loader. It accepts the loader's 256-bit weight stream qualified by six one-hot channel enables and files each word into one of six per-input-channel banks of 25 taps. Once every bank holds all 25 taps, it serves random-access tap reads to the layer-2 convolution array with one-cycle latency.

## Interface
Parameters:
- `WORD_W`, 256: weight word width; 16 lanes of signed 16-bit, lane k = bits [16k+15:16k] = output map k.
- `N_CH`, 6: input channels (banks).
- `N_TAP`, 25: taps per channel (5x5 kernel, row-major, tap = 5*row + col).

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `layer2_weight` in 256: signed weight word from the loader.
- `enable1`..`enable6` in 1 each: one-hot write qualifier; `enableN` targets channel N-1.
- `reload` in 1: restart capture; tap counters cleared, stored data kept.
- `rd_en` in 1: read request.
- `rd_ch` in 3: channel 0..5.
- `rd_tap` in 5: tap 0..24.
- `rd_data` out 256: tap word.
- `rd_valid` out 1: `rd_data` valid this cycle.
- `weights_ready` out 1: all banks full.
- `load_err` out 1: sticky protocol error.

## Operation
- FSM states:
  - LOAD (reset state).
  - READY.
- Per-channel tap counters `cnt[c]`, 5 bits, reset 0, saturate at 25.
- Write in LOAD when exactly one enable is high, say `enableN`, and `cnt[N-1]` < 25:
  - `layer2_weight` is written to bank N-1 at address `cnt[N-1]`.
  - `cnt[N-1]` increments.
- Enable pulses to a bank whose counter is already 25 are ignored. No write, no error. The loader's trailing cycles rely on this.
- Two or more enables high in the same cycle:
  - No write.
  - `load_err` is set. It is sticky and cleared only by `rst`.
- All enables low: no action.
- LOAD -> READY on the edge after which all `cnt[c]` == 25.
- READY:
  - Enables are ignored.
  - `reload` -> LOAD and all counters are cleared.
- `reload` in LOAD clears the counters and stays in LOAD. If `reload` and an enable are high in the same cycle, `reload` wins: no write.
- Read handling:
  - `rd_en` is accepted only in READY; otherwise it is ignored and `rd_valid` stays 0.
  - An out-of-range `rd_ch` (>=6) or `rd_tap` (>=25) still produces `rd_valid`=1, with `rd_data` = 0.
- Bank contents are not cleared by `rst`. They are undefined until written.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `weights_ready`=0, `load_err`=0, state LOAD, counters 0.
- Write takes effect at the capturing edge. A read of that tap is possible from the cycle after READY is entered.
- `weights_ready` is a registered decode of state == READY. It rises on the same edge as the LOAD->READY transition (the edge of the 150th valid write) and falls on the edge that accepts `reload`.
- Read latency is 1 cycle: a request sampled at edge t produces `rd_data`/`rd_valid` after edge t. `rd_valid` is a single-cycle pulse per request. Back-to-back reads give full throughput.
- `rd_data` holds its last value when `rd_valid`=0.
- A `rd_en` in the same cycle as an accepted `reload` is accepted, because the state is still READY, and it returns the stored data.
- `rst` mid-load aborts the load:
  - Counters cleared, state LOAD.
  - Any partially written data is stale and will be overwritten.

## Structure
- Shared package `layer2_pkg` holds:
  - `L2_WORD_W`=256, `L2_N_CH`=6, `L2_N_TAP`=25, `L2_LANES`=16, `L2_LANE_W`=16.
  - The state enum {LOAD, READY}.
- Sub-module `layer2_tap_ram`: 25x256 storage with one synchronous write port and one synchronous read port, read-first. Instantiated 6 times.
- The top level contains the counters, FSM, enable decode/error logic and the read-mux register. The read mux sits after the RAM outputs, selected by the registered `rd_ch` with a registered range flag.

## Test plan
- **Nominal load:** drive 150 words in loader order (words 0..24 with `enable1`, …, words 125..149 with `enable6`), word i = {16{16'(i)}}. Required: `weights_ready` rises on the edge of word 149; reading ch 3 tap 7 returns {16{16'd82}} with `rd_valid` one cycle after the request.
- **Trailing and excess enables:** keep `enable6` high 5 more cycles after load, with the data changed. Required: no overwrite; ch 5 tap 24 reads {16{16'd149}}; `load_err`=0.
- **Collision:** assert `enable2` and `enable3` together at word 30. Required: `load_err`=1 and stays 1; `cnt[1]` and `cnt[2]` unchanged; READY is not reached until 150 valid writes have occurred.
- **Reads outside READY and out of range:** `rd_en` during LOAD gives `rd_valid`=0. In READY, `rd_ch`=6 or `rd_tap`=25 gives `rd_valid`=1 and `rd_data`=0.
- **Reload and reset mid-operation:**
  - Assert `reload` in READY while reading. Required: the read returns the old data; `weights_ready` drops next edge; a full reload with new data then serves the new words.
  - Assert `rst` after 40 writes. Required: all outputs return to their reset values, and a fresh 150-word load completes normally.

Source files
------------

// File: rtl/layer2_pkg.sv
// Shared constants and state encoding for the layer-2 weight bank.
// Channel and tap index widths are kept here so the top and the RAM agree.
package layer2_pkg;

    localparam int L2_WORD_W = 256;
    localparam int L2_N_CH   = 6;
    localparam int L2_N_TAP  = 25;
    localparam int L2_LANES  = 16;
    localparam int L2_LANE_W = 16;
    localparam int L2_CH_W   = 3;
    localparam int L2_TAP_W  = 5;

    typedef enum logic {
        LOAD  = 1'b0,
        READY = 1'b1
    } l2_state_e;

endpackage

// File: rtl/layer2_tap_ram.sv
// One channel's 25-tap kernel store: single write port, single registered read port.
// Read-first; the read register is left unreset so the array maps onto block RAM.
module layer2_tap_ram
    import layer2_pkg::*;
#(
    parameter int DEPTH = L2_N_TAP,
    parameter int WIDTH = L2_WORD_W,
    parameter int AW    = L2_TAP_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/layer2_weight_bank.sv
// Captures the layer-2 loader stream into six per-channel tap banks, then serves
// one-cycle-latency random tap reads once every bank holds all 25 taps.
module layer2_weight_bank
    import layer2_pkg::*;
#(
    parameter int WORD_W = L2_WORD_W,
    parameter int N_CH   = L2_N_CH,
    parameter int N_TAP  = L2_N_TAP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   layer2_weight,
    input  logic                enable1,
    input  logic                enable2,
    input  logic                enable3,
    input  logic                enable4,
    input  logic                enable5,
    input  logic                enable6,
    input  logic                reload,
    input  logic                rd_en,
    input  logic [L2_CH_W-1:0]  rd_ch,
    input  logic [L2_TAP_W-1:0] rd_tap,
    output logic [WORD_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                weights_ready,
    output logic                load_err
);

    l2_state_e                          state_reg, state_next;
    logic [N_CH-1:0][L2_TAP_W-1:0]      cnt_reg, cnt_next;
    logic [N_CH-1:0]                    en, wr_en, full_next;
    logic                               multi_en, single_en, load_active;
    logic                               rd_accept, ch_ok, tap_ok;
    logic [L2_TAP_W-1:0]                rd_addr;
    logic [WORD_W-1:0]                  ram_q [N_CH];
    logic [WORD_W-1:0]                  rd_mux;
    logic [L2_CH_W-1:0]                 rd_ch_reg;
    logic                               rd_hit_reg;
    logic                               rd_valid_reg, weights_ready_reg, load_err_reg;

    assign en          = {enable6, enable5, enable4, enable3, enable2, enable1};
    // Clearing the lowest set bit leaves something only if two or more enables are high.
    assign multi_en    = (en & (en - {{(N_CH-1){1'b0}}, 1'b1})) != '0;
    assign single_en   = (en != '0) && !multi_en;
    assign load_active = (state_reg == LOAD) && !reload;

    assign rd_accept = rd_en && (state_reg == READY);
    assign ch_ok     = rd_ch < L2_CH_W'(N_CH);
    assign tap_ok    = rd_tap < L2_TAP_W'(N_TAP);
    assign rd_addr   = tap_ok ? rd_tap : '0;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_bank
            assign wr_en[gi]     = load_active && single_en && en[gi]
                                   && (cnt_reg[gi] < L2_TAP_W'(N_TAP));
            assign cnt_next[gi]  = reload    ? '0 :
                                   wr_en[gi] ? cnt_reg[gi] + L2_TAP_W'(1) : cnt_reg[gi];
            assign full_next[gi] = cnt_next[gi] == L2_TAP_W'(N_TAP);

            layer2_tap_ram #(
                .DEPTH (N_TAP),
                .WIDTH (WORD_W),
                .AW    (L2_TAP_W)
            ) u_ram (
                .clk   (clk),
                .we    (wr_en[gi]),
                .waddr (cnt_reg[gi]),
                .wdata (layer2_weight),
                .re    (rd_accept),
                .raddr (rd_addr),
                .rdata (ram_q[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD:    if (!reload && (&full_next)) state_next = READY;
            READY:   if (reload) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= LOAD;
            cnt_reg           <= '0;
            weights_ready_reg <= 1'b0;
            load_err_reg      <= 1'b0;
            rd_valid_reg      <= 1'b0;
            rd_ch_reg         <= '0;
            rd_hit_reg        <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            weights_ready_reg <= (state_next == READY);
            load_err_reg      <= load_err_reg | (load_active & multi_en);
            rd_valid_reg      <= rd_accept;
            if (rd_accept) begin
                rd_ch_reg  <= rd_ch;
                rd_hit_reg <= ch_ok && tap_ok;
            end
        end
    end

    // Mux after the RAM registers; a cleared hit flag forces zero and holds across idle cycles.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_hit_reg && (rd_ch_reg == L2_CH_W'(c))) rd_mux = ram_q[c];
        end
    end

    assign rd_data       = rd_mux;
    assign rd_valid      = rd_valid_reg;
    assign weights_ready = weights_ready_reg;
    assign load_err      = load_err_reg;

endmodule

// File: tb/tb_layer2_weight_bank.sv
// Directed bench for layer2_weight_bank: read responses are scoreboarded by a
// negedge monitor, status outputs are checked inline by the stimulus process.
module tb_layer2_weight_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] layer2_weight;
    logic         enable1, enable2, enable3, enable4, enable5, enable6;
    logic         reload;
    logic         rd_en;
    logic [2:0]   rd_ch;
    logic [4:0]   rd_tap;
    logic [255:0] rd_data;
    logic         rd_valid;
    logic         weights_ready;
    logic         load_err;

    logic [255:0] exp_q [$];
    logic [255:0] exp_word;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    layer2_weight_bank dut (
        .clk           (clk),
        .rst           (rst),
        .layer2_weight (layer2_weight),
        .enable1       (enable1),
        .enable2       (enable2),
        .enable3       (enable3),
        .enable4       (enable4),
        .enable5       (enable5),
        .enable6       (enable6),
        .reload        (reload),
        .rd_en         (rd_en),
        .rd_ch         (rd_ch),
        .rd_tap        (rd_tap),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .weights_ready (weights_ready),
        .load_err      (load_err)
    );

    function automatic logic [255:0] mkw(input int v);
        logic [15:0] h;
        h = 16'(v);
        return {16{h}};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_valid=1 data %0h, expected no response", rd_data);
            end else begin
                exp_word = exp_q.pop_front();
                check("rd_data", rd_data, exp_word);
                $display("read response data=%0h", rd_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_en(input int ch);
        enable1 = (ch == 0);
        enable2 = (ch == 1);
        enable3 = (ch == 2);
        enable4 = (ch == 3);
        enable5 = (ch == 4);
        enable6 = (ch == 5);
    endtask

    task automatic write(input int ch, input logic [255:0] d);
        set_en(ch);
        layer2_weight = d;
        tick();
        set_en(-1);
    endtask

    task automatic read(input int ch, input int tap, input logic [255:0] exp, input bit expect_resp);
        rd_ch  = 3'(ch);
        rd_tap = 5'(tap);
        rd_en  = 1'b1;
        if (expect_resp) exp_q.push_back(exp);
        $display("read request ch=%0d tap=%0d", ch, tap);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic load_ch(input int ch, input int base, input bit edge_chk);
        for (int t = 0; t < 25; t++) begin
            if (edge_chk && t == 24) check("ready_before_last", weights_ready, 0);
            write(ch, mkw(base + ch * 25 + t));
        end
        $display("loaded ch=%0d base=%0d", ch, base);
    endtask

    task automatic load_all(input int base, input bit collide);
        for (int i = 0; i < 150; i++) begin
            if (collide && i == 30) begin
                enable2 = 1'b1;
                enable3 = 1'b1;
                layer2_weight = mkw(16'h0BAD);
                tick();
                set_en(-1);
                check("load_err_set", load_err, 1);
                $display("collision cycle load_err=%0b", load_err);
            end
            if (i == 149) check("ready_before_word149", weights_ready, 0);
            write(i / 25, mkw(base + i));
        end
        check("ready_after_word149", weights_ready, 1);
        $display("full load base=%0d weights_ready=%0b", base, weights_ready);
    endtask

    task automatic check_reset_values();
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_weights_ready", weights_ready, 0);
        check("rst_load_err", load_err, 0);
    endtask

    initial begin
        rst = 1'b1;
        layer2_weight = '0;
        set_en(-1);
        reload = 1'b0;
        rd_en = 1'b0;
        rd_ch = '0;
        rd_tap = '0;
        repeat (3) tick();
        check_reset_values();
        rst = 1'b0;
        tick();

        // Read while loading is ignored
        read(0, 0, '0, 1'b0);
        check("rd_valid_in_load", rd_valid, 0);

        // Nominal load, word i = i
        load_all(0, 1'b0);
        check("load_err_nominal", load_err, 0);
        read(3, 7, mkw(82), 1'b1);
        check("rd_valid_latency", rd_valid, 1);
        read(0, 0, mkw(0), 1'b1);
        read(5, 24, mkw(149), 1'b1);

        // Trailing enable6 after the load completes
        repeat (5) write(5, mkw(16'hDEAD));
        read(5, 24, mkw(149), 1'b1);
        check("load_err_trailing", load_err, 0);

        // Out-of-range reads return zero with valid
        read(6, 0, '0, 1'b1);
        read(0, 25, '0, 1'b1);
        read(3, 7, mkw(82), 1'b1);

        // Reload while reading: old data returned, ready drops on that edge
        reload = 1'b1;
        read(3, 7, mkw(82), 1'b1);
        reload = 1'b0;
        check("ready_after_reload", weights_ready, 0);
        read(1, 1, '0, 1'b0);
        check("rd_valid_after_reload", rd_valid, 0);

        // Reload with new data, ch5 first with excess enables while still loading
        load_ch(5, 1000, 1'b0);
        repeat (5) write(5, mkw(16'hBEEF));
        check("load_err_excess", load_err, 0);
        check("ready_partial", weights_ready, 0);
        for (int c = 0; c < 5; c++) load_ch(c, 1000, c == 4);
        check("ready_reload_done", weights_ready, 1);
        read(5, 24, mkw(1149), 1'b1);
        read(5, 0, mkw(1125), 1'b1);
        read(0, 3, mkw(1003), 1'b1);
        read(4, 24, mkw(1124), 1'b1);

        // Collision at word 30
        reload = 1'b1;
        tick();
        reload = 1'b0;
        load_all(2000, 1'b1);
        check("load_err_sticky", load_err, 1);
        read(1, 5, mkw(2030), 1'b1);
        read(2, 0, mkw(2050), 1'b1);
        read(1, 4, mkw(2029), 1'b1);

        // Reset after 40 writes, then a fresh load
        reload = 1'b1;
        tick();
        reload = 1'b0;
        for (int i = 0; i < 40; i++) write(i / 25, mkw(3000 + i));
        rst = 1'b1;
        tick();
        check_reset_values();
        rst = 1'b0;
        tick();
        load_all(3000, 1'b0);
        check("load_err_after_rst", load_err, 0);
        read(4, 10, mkw(3110), 1'b1);
        read(0, 0, mkw(3000), 1'b1);

        repeat (3) tick();
        check("scoreboard_drain", 256'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
